rx_word_packer: RTL and testbench
=================================

# rx_word_packer

Receive-side counterpart of the 128-bit to 32-bit output parser. Pops 32-bit words from the RX FIFO and packs groups of `WORDS` consecutive words into one `WORDS*DATA_W`-bit block for the downstream consumer. The consumer takes each block with a valid/accept handshake. The block sits between the RX FIFO read port and the processing core.

## Interface
- `DATA_W`, 32: FIFO word width.
- `WORDS`, 4: words per block. Must be ≥2.
- `TIMEOUT_CYCLES`, 256: idle-flush threshold; used only with `RX_TIMEOUT_EN`.

- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous active-low reset.
- `FIFO_rx_dout` in `DATA_W`: FIFO read data, valid the cycle after `FIFO_rx_rd_en`.
- `FIFO_rx_empty` in 1: FIFO empty flag.
- `FIFO_rx_rd_en` out 1: FIFO pop request; combinational.
- `data_flat` out `WORDS*DATA_W`: assembled block; first word received occupies the MSBs.
- `data_valid` out 1: `data_flat` is complete and stable.
- `data_accept` in 1: consumer takes the block when high together with `data_valid`.
- `data_partial` out 1: block was flushed by timeout; tied 0 without the macro.
- `Parsar_busy` out 1: high in FILL or FULL.

## Operation
- Counters:
  - `issued` (0..`WORDS`): reads issued for the current block.
  - `rd_pending`: a read was issued last cycle.
  - `got` (0..`WORDS`): words captured.
- `FIFO_rx_rd_en = !FIFO_rx_empty && issued < WORDS && state != FULL`.
- Capture when `rd_pending` is 1: `FIFO_rx_dout` goes into lane `WORDS-1-got` (bits `[(WORDS-got)*DATA_W-1 -: DATA_W]`), then `got` increments.
- States:
  - IDLE (`issued==0`, `got==0`): moves to FILL on the first `FIFO_rx_rd_en`.
  - FILL: moves to FULL on the edge that captures word `WORDS-1`.
  - FULL: `data_valid=1`; `data_flat` is frozen; no reads are issued. `data_valid && data_accept` at a rising edge clears `issued`, `got` and `data_partial`, and moves to IDLE.
- Boundaries:
  - FIFO empty mid-block: `FIFO_rx_rd_en` drops; counters and lanes hold; reads resume when data returns.
  - `data_accept` while not FULL: ignored.
  - Reset mid-block: all state clears; lanes already captured are discarded; a word in flight (`rd_pending`) is lost.
- Reset values: `FIFO_rx_rd_en=0` (`FIFO_rx_empty` reset-forced high by the FIFO, else combinational), `data_flat=0`, `data_valid=0`, `data_partial=0`, `Parsar_busy=0`, state IDLE.

## Timing
- Back-to-back reads: `FIFO_rx_rd_en` is high in cycles 0..`WORDS-1` when the FIFO stays non-empty.
- Word k is captured at the end of cycle k+1.
- `data_valid` rises in cycle `WORDS+1`; that is 5 cycles after the first read when `WORDS=4`.
- Accept sampled at the end of cycle t: `data_valid` is low in t+1, and `FIFO_rx_rd_en` may assert in t+1.
- Sustained throughput: one block per `WORDS+2` cycles.
- `data_flat` changes only on capture edges in FILL; it never changes while `data_valid` is high.

## Configuration
- `RX_TIMEOUT_EN` defined:
  - An idle counter runs in FILL while `rd_pending==0` and `FIFO_rx_rd_en==0`, and clears on any read or capture.
  - At `TIMEOUT_CYCLES` consecutive idle cycles the block flushes: uncaptured lanes are zero-filled, the state goes to FULL, and `data_valid=1`, `data_partial=1`.
  - A timeout with no pending read can occur only with `issued==got`.
- `RX_TIMEOUT_EN` undefined: no counter; FILL waits indefinitely; `data_partial` is constant 0.

## Test plan
- Push 11223344, 55667788, 99AABBCC, DDEEFF00 into a non-empty FIFO, `data_accept=1` → rd_en high in cycles 0-3; `data_valid` high in cycle 5; `data_flat=112233445566778899AABBCCDDEEFF00`; `data_valid` low the cycle after.
- 16 blocks back-to-back with accept tied high → 16 `data_valid` pulses 6 cycles apart; data matches FIFO order; no word dropped or duplicated.
- FIFO empty after word 2 for 20 cycles, then 2 more words → rd_en low during the gap; block completes correctly with no `data_partial`.
- Hold `data_accept=0` for 10 cycles in FULL with FIFO non-empty → no rd_en; `data_flat` stable; accept in cycle 10 → rd_en in cycle 11.
- Drop `rst_n` after 2 captured words → all outputs 0 immediately; the next full block after reset assembles cleanly.
- With `RX_TIMEOUT_EN` and `TIMEOUT_CYCLES=8`: 3 words then FIFO empty → after 8 idle cycles `data_valid=1`, `data_partial=1`, low 32 bits `00000000`.

Source files
------------

// File: rtl/rx_word_packer.sv
// rx_word_packer: pops DATA_W-bit words from the RX FIFO and packs WORDS of them into one block with a valid/accept handshake
// Ports: clk, rst_n (async active-low); FIFO_rx_dout/FIFO_rx_empty in, FIFO_rx_rd_en out (FIFO read side);
//        data_flat/data_valid/data_partial out, data_accept in (consumer side); Parsar_busy out (high in FILL or FULL).
// Optional feature: define RX_TIMEOUT_EN to flush a partial block (zero-filled, data_partial=1) after TIMEOUT_CYCLES idle cycles in FILL.
module rx_word_packer #(
  parameter int DATA_W         = 32,
  parameter int WORDS          = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [DATA_W-1:0]         FIFO_rx_dout,
  input  logic                      FIFO_rx_empty,
  output logic                      FIFO_rx_rd_en,
  output logic [WORDS*DATA_W-1:0]   data_flat,
  output logic                      data_valid,
  input  logic                      data_accept,
  output logic                      data_partial,
  output logic                      Parsar_busy
);
  if (WORDS < 2 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("rx_word_packer: WORDS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end
  localparam int CW = $clog2(WORDS + 1);
  typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;
  state_t                    state_q, state_d;
  logic [CW-1:0]             issued_q, issued_d, got_q, got_d;
  logic                      rd_pending_q;
  logic [WORDS*DATA_W-1:0]   data_q, data_d;
  logic                      take, last_cap, timeout;
  assign FIFO_rx_rd_en = !FIFO_rx_empty && issued_q < CW'(WORDS) && state_q != FULL;
  assign take          = state_q == FULL && data_accept;
  assign last_cap      = rd_pending_q && got_q == CW'(WORDS - 1);
  assign data_flat     = data_q;
  assign data_valid    = state_q == FULL;
  assign Parsar_busy   = state_q != IDLE;
`ifdef RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_q, idle_d;
  logic          idle, partial_q, partial_d;
  // Idle means FILL with nothing in flight and nothing being requested.
  assign idle         = state_q == FILL && !rd_pending_q && !FIFO_rx_rd_en;
  assign timeout      = idle && idle_q == TW'(TIMEOUT_CYCLES - 1);
  assign idle_d       = idle ? idle_q + TW'(1) : '0;
  assign partial_d    = take ? 1'b0 : timeout ? 1'b1 : partial_q;
  assign data_partial = partial_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      partial_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      partial_q <= partial_d;
    end
  end
`else
  assign timeout      = 1'b0;
  assign data_partial = 1'b0;
`endif
  always_comb begin
    issued_d = take ? '0 : issued_q + CW'(FIFO_rx_rd_en);
    got_d    = take ? '0 : got_q + CW'(rd_pending_q);
    data_d   = data_q;
    // First word lands in the top lane; a flush clears every lane not yet captured.
    for (int j = 0; j < WORDS; j++) begin
      if (rd_pending_q && got_q == CW'(WORDS - 1 - j)) data_d[j*DATA_W +: DATA_W] = FIFO_rx_dout;
      if (timeout && got_q < CW'(WORDS - j)) data_d[j*DATA_W +: DATA_W] = '0;
    end
    state_d = take                                      ? IDLE :
              (state_q == IDLE && FIFO_rx_rd_en)        ? FILL :
              (state_q == FILL && (last_cap || timeout)) ? FULL : state_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      issued_q     <= '0;
      got_q        <= '0;
      rd_pending_q <= 1'b0;
      data_q       <= '0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      got_q        <= got_d;
      rd_pending_q <= FIFO_rx_rd_en;
      data_q       <= data_d;
    end
  end
endmodule

// File: tb/tb_rx_word_packer.sv
// tb_rx_word_packer: scoreboard bench for rx_word_packer with a behavioural FIFO model
module tb_rx_word_packer;
  localparam int DW = 32, NW = 4, BW = DW * NW, TO = 8;
  logic          clk = 1'b0, rst_n = 1'b0, gate = 1'b0, accept = 1'b0;
  logic [DW-1:0] dout;
  logic          empty, rd_en, valid, partial, busy;
  logic [BW-1:0] flat;
  logic [DW-1:0] mem [0:1023];
  int            wp = 0, rp = 0, cyc = 0, last_acc = -1;
  int            errors = 0, checks = 0;
  bit            gap_chk = 1'b0;
  typedef struct packed { logic [BW-1:0] d; logic p; } exp_t;
  exp_t          exp_q[$];
  exp_t          e;
  always #5 clk = ~clk;
  // FIFO model: stimulus owns wp, this process owns rp; reset discards contents.
  assign empty = !rst_n || gate || wp == rp;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rp   <= wp;
      dout <= '0;
    end else if (rd_en) begin
      dout <= mem[rp];
      rp   <= rp + 1;
    end
  end
  always @(posedge clk) cyc <= cyc + 1;
  rx_word_packer #(.DATA_W(DW), .WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .FIFO_rx_dout(dout), .FIFO_rx_empty(empty), .FIFO_rx_rd_en(rd_en),
    .data_flat(flat), .data_valid(valid), .data_accept(accept), .data_partial(partial), .Parsar_busy(busy)
  );
  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push_word(input logic [DW-1:0] w);
    mem[wp] = w;
    wp++;
  endtask
  task automatic push_block(input logic [BW-1:0] blk);
    exp_q.push_back('{blk, 1'b0});
    for (int i = 0; i < NW; i++) push_word(blk[BW-1-i*DW -: DW]);
  endtask
  task automatic drain(input string tag, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    #1;
  endtask
  function automatic logic [BW-1:0] rnd_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  // Consumer side: every handshake pops the scoreboard.
  always @(negedge clk) begin
    if (!gap_chk) last_acc = -1;
    if (rst_n && valid && accept) begin
      if (exp_q.size() == 0) check("sb_empty_at_valid", exp_q.size(), 1);
      else begin
        e = exp_q.pop_front();
        check("block_data", flat, e.d);
        check("block_partial", partial, e.p);
      end
      if (gap_chk) begin
        if (last_acc >= 0) check("block_gap", cyc - last_acc, 6);
        last_acc = cyc;
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end
  initial begin
    logic [BW-1:0] blk, d0;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", rd_en, 0);
    check("rst_flat", flat, 0);
    check("rst_valid", valid, 0);
    check("rst_partial", partial, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_rd_en", rd_en, 0);
    // Single block, exact cycle timing.
    accept = 1'b1;
    push_block(128'h112233445566778899AABBCCDDEEFF00);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check($sformatf("t1_rd_en_c%0d", c), rd_en, c < 4);
      check($sformatf("t1_valid_c%0d", c), valid, c == 5);
    end
    drain("t1_drain", 10);
    // 16 blocks back-to-back, accept tied high.
    gap_chk = 1'b1;
    for (int b = 0; b < 16; b++) push_block(rnd_block());
    drain("t2_drain", 200);
    gap_chk = 1'b0;
    // FIFO starves after two words for 20 cycles.
    blk = rnd_block();
    exp_q.push_back('{blk, 1'b0});
    push_word(blk[127:96]);
    push_word(blk[95:64]);
    repeat (3) @(posedge clk);
    #1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check("t3_gap_rd_en", rd_en, 0);
      check("t3_gap_valid", valid, 0);
      check("t3_gap_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    push_word(blk[63:32]);
    push_word(blk[31:0]);
    drain("t3_drain", 20);
    // Back-pressure: accept held low for 10 cycles while the FIFO holds more data.
    accept = 1'b0;
    push_block(rnd_block());
    push_block(rnd_block());
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!valid && n < 20);
    check("t4_valid_rise", valid, 1);
    d0 = flat;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      check("t4_hold_rd_en", rd_en, 0);
      check("t4_hold_valid", valid, 1);
      check("t4_hold_flat", flat, d0);
    end
    @(posedge clk);
    #1;
    accept = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t4_rd_en_after_accept", rd_en, 1);
    check("t4_valid_after_accept", valid, 0);
    drain("t4_drain", 30);
    // Reset after two captured words.
    blk = rnd_block();
    for (int i = 0; i < NW; i++) push_word(blk[BW-1-i*DW -: DW]);
    repeat (4) @(negedge clk);
    check("t5_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_rd_en", rd_en, 0);
    check("t5_rst_flat", flat, 0);
    check("t5_rst_valid", valid, 0);
    check("t5_rst_partial", partial, 0);
    check("t5_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_block(rnd_block());
    drain("t5_drain", 20);
`ifdef RX_TIMEOUT_EN
    // Three words, then the FIFO runs dry: flush after TO idle cycles.
    blk = rnd_block();
    blk[31:0] = '0;
    exp_q.push_back('{blk, 1'b1});
    for (int i = 0; i < 3; i++) push_word(blk[BW-1-i*DW -: DW]);
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      check($sformatf("to_valid_c%0d", c), valid, c == 12);
      if (c == 12) begin
        check("to_partial", partial, 1);
        check("to_low_word", flat[31:0], 0);
      end
    end
    drain("to_drain", 10);
    check("to_partial_cleared", partial, 0);
`endif
    check("sb_final", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
